hazard_controller: RTL and testbench

Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (F, D, E, M, W). It drives iStall*/iFlush* of every stage pipeline register and the E-stage forwarding mux selects. It also sequences multi-cycle instruction-memory and data-memory waits, pending branch redirects, and a data-memory timeout watchdog.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/forward_unit.sv | 19 +
 rtl/hazard_controller.sv | 179 +++++++++++++++++
 tb/tb_hazard_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the per-cycle control bundle.
package hazard_pkg;

  localparam int REG_W   = 5;
  localparam int NUM_SRC = 2;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    RPEND = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
    logic redirect_f;
  } hz_ctrl_t;

  // A writer hits a source only if it writes, targets a real register and matches.
  function automatic logic reg_hit(input logic we, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] src);
    return we && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// E-stage operand forwarding select for one source register; M beats W.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_REG;
    if (reg_hit(reg_write_w, rd_w, src)) sel = FWD_W;
    if (reg_hit(reg_write_m, rd_m, src)) sel = FWD_M;
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with D-mem
// wait watchdog. Define HAZARD_PERF_EN to add stall/flush event counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic [REG_W-1:0] iRs1D,
  input  logic [REG_W-1:0] iRs2D,
  input  logic [REG_W-1:0] iRs1E,
  input  logic [REG_W-1:0] iRs2E,
  input  logic [REG_W-1:0] iRdE,
  input  logic [REG_W-1:0] iRdM,
  input  logic [REG_W-1:0] iRdW,
  input  logic             iMemReadE,
  input  logic             iRegWriteM,
  input  logic             iRegWriteW,
  input  logic             iMispredictE,
  input  logic             iIMemReadyF,
  input  logic             iDMemReqM,
  input  logic             iDMemReadyM,
  output logic             oStallF,
  output logic             oStallD,
  output logic             oStallE,
  output logic             oStallM,
  output logic             oFlushD,
  output logic             oFlushE,
  output logic             oFlushW,
  output logic             oRedirectF,
  output logic [1:0]       oForwardAE,
  output logic [1:0]       oForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      oStallCycles,
  output logic [31:0]      oFlushCount,
`endif
  output logic             oMemTimeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(MEM_TIMEOUT - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  hz_ctrl_t         ctrl, ctrl_o;
  logic             dmem_wait, load_use, flush_mp;

  // ---------------- forwarding ----------------
  logic [NUM_SRC-1:0][REG_W-1:0] src_e;
  logic [NUM_SRC-1:0][1:0]       fwd_sel;

  assign src_e = {iRs2E, iRs1E};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    forward_unit u_fwd (
      .src         (src_e[s]),
      .rd_m        (iRdM),
      .rd_w        (iRdW),
      .reg_write_m (iRegWriteM),
      .reg_write_w (iRegWriteW),
      .sel         (fwd_sel[s])
    );
  end

  // ---------------- control ----------------
  assign dmem_wait = iDMemReqM && !iDMemReadyM;
  assign load_use  = iMemReadE && (iRdE != REG_ZERO) &&
                     ((iRdE == iRs1D) || (iRdE == iRs2D));

  always_comb begin
    ctrl      = '0;
    state_d   = state_q;
    cnt_d     = '0;
    timeout_d = timeout_q;
    flush_mp  = 1'b0;
    if (dmem_wait) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
      // A pending redirect survives the wait by simply staying in RPEND.
      state_d = (state_q == RPEND) ? RPEND : DWAIT;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_TRIP) timeout_d = 1'b1;
    end else if (state_q == RPEND) begin
      ctrl.flush_d = 1'b1;
      if (iIMemReadyF) begin
        ctrl.redirect_f = 1'b1;
        state_d         = RUN;
      end else begin
        ctrl.stall_f = 1'b1;
      end
    end else begin
      // DWAIT release cycle behaves like RUN; a frozen mispredict is seen now.
      state_d = RUN;
      if (iMispredictE) begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
        flush_mp     = 1'b1;
        if (iIMemReadyF) begin
          ctrl.redirect_f = 1'b1;
        end else begin
          ctrl.stall_f = 1'b1;
          state_d      = RPEND;
        end
      end else if (load_use) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end else if (!iIMemReadyF) begin
        ctrl.stall_f = 1'b1;
        ctrl.flush_d = 1'b1;
      end
    end
  end

  // Reset forces bubbles into D/E/W immediately, without waiting for a clock.
  always_comb begin
    ctrl_o = ctrl;
    if (!iRstN) begin
      ctrl_o         = '0;
      ctrl_o.flush_d = 1'b1;
      ctrl_o.flush_e = 1'b1;
      ctrl_o.flush_w = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign oStallF     = ctrl_o.stall_f;
  assign oStallD     = ctrl_o.stall_d;
  assign oStallE     = ctrl_o.stall_e;
  assign oStallM     = ctrl_o.stall_m;
  assign oFlushD     = ctrl_o.flush_d;
  assign oFlushE     = ctrl_o.flush_e;
  assign oFlushW     = ctrl_o.flush_w;
  assign oRedirectF  = ctrl_o.redirect_f;
  assign oForwardAE  = iRstN ? fwd_sel[0] : FWD_REG;
  assign oForwardBE  = iRstN ? fwd_sel[1] : FWD_REG;
  assign oMemTimeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (ctrl.stall_f ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (flush_mp ? 32'd1 : 32'd0);
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign oStallCycles = stall_cnt_q;
  assign oFlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: combinational vector table plus
// multi-cycle sequences for D-mem wait, redirect pending, watchdog and reset.
module tb_hazard_controller;

  localparam int MT = 64;

  logic       iClk = 1'b0;
  logic       iRstN = 1'b0;
  logic [4:0] iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iRdM, iRdW;
  logic       iMemReadE, iRegWriteM, iRegWriteW, iMispredictE;
  logic       iIMemReadyF, iDMemReqM, iDMemReadyM;
  logic       oStallF, oStallD, oStallE, oStallM;
  logic       oFlushD, oFlushE, oFlushW, oRedirectF, oMemTimeout;
  logic [1:0] oForwardAE, oForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] oStallCycles, oFlushCount;
`endif

  hazard_controller #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
    .iClk(iClk), .iRstN(iRstN),
    .iRs1D(iRs1D), .iRs2D(iRs2D), .iRs1E(iRs1E), .iRs2E(iRs2E),
    .iRdE(iRdE), .iRdM(iRdM), .iRdW(iRdW),
    .iMemReadE(iMemReadE), .iRegWriteM(iRegWriteM), .iRegWriteW(iRegWriteW),
    .iMispredictE(iMispredictE), .iIMemReadyF(iIMemReadyF),
    .iDMemReqM(iDMemReqM), .iDMemReadyM(iDMemReadyM),
    .oStallF(oStallF), .oStallD(oStallD), .oStallE(oStallE), .oStallM(oStallM),
    .oFlushD(oFlushD), .oFlushE(oFlushE), .oFlushW(oFlushW),
    .oRedirectF(oRedirectF), .oForwardAE(oForwardAE), .oForwardBE(oForwardBE),
`ifdef HAZARD_PERF_EN
    .oStallCycles(oStallCycles), .oFlushCount(oFlushCount),
`endif
    .oMemTimeout(oMemTimeout)
  );

  always #5 iClk = ~iClk;

  // {stallF,D,E,M, flushD,E,W, redirect, fwdA[1:0], fwdB[1:0]}
  logic [11:0] outs;
  assign outs = {oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oFlushW,
                 oRedirectF, oForwardAE, oForwardBE};

  localparam logic [11:0] O_IDLE  = 12'h000;
  localparam logic [11:0] O_LU    = 12'hC40;
  localparam logic [11:0] O_MISP  = 12'h0D0;
  localparam logic [11:0] O_MISPW = 12'h8C0;
  localparam logic [11:0] O_IWAIT = 12'h880;
  localparam logic [11:0] O_DWAIT = 12'hF20;
  localparam logic [11:0] O_REDIR = 12'h090;
  localparam logic [11:0] O_RST   = 12'h0E0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic now(input string nm, input logic [11:0] exp);
    #1;
    chk(nm, outs, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic idle();
    iRs1D = 5'd1; iRs2D = 5'd2; iRs1E = 5'd3; iRs2E = 5'd4;
    iRdE = 5'd7; iRdM = 5'd8; iRdW = 5'd9;
    iMemReadE = 1'b0; iRegWriteM = 1'b1; iRegWriteW = 1'b1;
    iMispredictE = 1'b0; iIMemReadyF = 1'b1;
    iDMemReqM = 1'b0; iDMemReadyM = 1'b0;
  endtask

  typedef struct {
    string      nm;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       memrd, rwm, rww, misp, irdy;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mk(input string nm,
      input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
      input logic memrd, rwm, rww, misp, irdy, input logic [11:0] exp);
    vec_t v;
    v.nm = nm; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.memrd = memrd; v.rwm = rwm;
    v.rww = rww; v.misp = misp; v.irdy = irdy; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    //             name          rs1d rs2d rs1e rs2e rde rdm rdw  ld wm ww mp ir  expected
    tbl[0]  = mk("idle",        1, 2, 3, 4, 7, 8, 9,  0, 1, 1, 0, 1, 12'h000);
    tbl[1]  = mk("lu_rs1",      5, 1, 3, 4, 5, 8, 9,  1, 1, 1, 0, 1, 12'hC40);
    tbl[2]  = mk("lu_rs2",      1, 5, 3, 4, 5, 8, 9,  1, 1, 1, 0, 1, 12'hC40);
    tbl[3]  = mk("lu_x0",       0, 2, 3, 4, 0, 8, 9,  1, 1, 1, 0, 1, 12'h000);
    tbl[4]  = mk("lu_nomatch",  6, 1, 3, 4, 5, 8, 9,  1, 1, 1, 0, 1, 12'h000);
    tbl[5]  = mk("fwd_m_beats_w",1,2, 3, 4, 7, 3, 3,  0, 1, 1, 0, 1, 12'h008);
    tbl[6]  = mk("fwd_w_both",  1, 2, 3, 3, 7, 8, 3,  0, 1, 1, 0, 1, 12'h005);
    tbl[7]  = mk("fwd_x0",      1, 2, 0, 0, 7, 0, 0,  0, 1, 1, 0, 1, 12'h000);
    tbl[8]  = mk("fwd_m_nowr",  1, 2, 3, 4, 7, 4, 4,  0, 0, 1, 0, 1, 12'h001);
    tbl[9]  = mk("fwd_w_nowr",  1, 2, 3, 4, 7, 8, 3,  0, 1, 0, 0, 1, 12'h000);
    tbl[10] = mk("misp_rdy",    1, 2, 3, 4, 7, 8, 9,  0, 1, 1, 1, 1, 12'h0D0);
    tbl[11] = mk("misp_and_lu", 5, 2, 3, 4, 5, 8, 9,  1, 1, 1, 1, 1, 12'h0D0);
    tbl[12] = mk("imem_wait",   1, 2, 3, 4, 7, 8, 9,  0, 1, 1, 0, 0, 12'h880);
    tbl[13] = mk("lu_over_iw",  5, 2, 3, 4, 5, 8, 9,  1, 1, 1, 0, 0, 12'hC40);
    tbl[14] = mk("fwd_in_stall",5, 2, 2, 4, 5, 2, 9,  1, 1, 1, 0, 1, 12'hC48);

    idle();
    iRs1E = 5'd3; iRdM = 5'd3;   // a forward match that reset must mask
    #3;
    chk("reset_outs", outs, O_RST);
    chk1("reset_timeout", oMemTimeout, 1'b0);
    @(negedge iClk);
    iRstN = 1'b1;
    idle();
    tick();

    foreach (tbl[i]) begin
      iRs1D = tbl[i].rs1d; iRs2D = tbl[i].rs2d; iRs1E = tbl[i].rs1e;
      iRs2E = tbl[i].rs2e; iRdE = tbl[i].rde; iRdM = tbl[i].rdm; iRdW = tbl[i].rdw;
      iMemReadE = tbl[i].memrd; iRegWriteM = tbl[i].rwm; iRegWriteW = tbl[i].rww;
      iMispredictE = tbl[i].misp; iIMemReadyF = tbl[i].irdy;
      now(tbl[i].nm, tbl[i].exp);
      tick();
    end

    // Load-use: one stall cycle, then the bubble in E releases it.
    idle(); iMemReadE = 1'b1; iRdE = 5'd5; iRs1D = 5'd6; iRs2D = 5'd5;
    now("lu_cycle", O_LU);
    tick();
    iMemReadE = 1'b0; iRdE = 5'd0;
    now("lu_release", O_IDLE);
    tick();

    // D-mem wait of 5 cycles, forwarding stays live.
    idle(); iDMemReqM = 1'b1; iRdM = 5'd3;
    for (int k = 0; k < 5; k++) begin
      now($sformatf("dwait5_c%0d", k), O_DWAIT | 12'h008);
      tick();
    end
    iDMemReadyM = 1'b1;
    now("dwait5_release", 12'h008);
    tick();
    idle();
    now("dwait5_after", O_IDLE);
    chk1("dwait5_no_timeout", oMemTimeout, 1'b0);

    // Mispredict while I-mem not ready: RPEND held, redirect on ready.
    iMispredictE = 1'b1; iIMemReadyF = 1'b0;
    now("rp_misp", O_MISPW);
    tick();
    iMispredictE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      now($sformatf("rp_hold_c%0d", k), O_IWAIT);
      tick();
    end
    iIMemReadyF = 1'b1;
    now("rp_redirect", O_REDIR);
    tick();
    now("rp_back_run", O_IDLE);

    // Mispredict during DWAIT: ignored until the wait ends.
    iDMemReqM = 1'b1; iMispredictE = 1'b1;
    now("mdw_wait0", O_DWAIT);
    tick();
    now("mdw_wait1", O_DWAIT);
    tick();
    iDMemReadyM = 1'b1;
    now("mdw_release", O_MISP);
    tick();
    idle();
    now("mdw_after", O_IDLE);

    // D-mem wait inside RPEND keeps the redirect pending.
    iMispredictE = 1'b1; iIMemReadyF = 1'b0;
    now("rpd_misp", O_MISPW);
    tick();
    iMispredictE = 1'b0; iDMemReqM = 1'b1;
    now("rpd_dwait", O_DWAIT);
    tick();
    iDMemReqM = 1'b0; iIMemReadyF = 1'b1;
    now("rpd_redirect", O_REDIR);
    tick();
    now("rpd_after", O_IDLE);

    // Watchdog: wait of exactly MT cycles sets the sticky flag.
    iDMemReqM = 1'b1; iDMemReadyM = 1'b0;
    for (int k = 1; k <= MT; k++) begin
      tick();
      chk1($sformatf("wd_c%0d", k), oMemTimeout, (k >= MT));
    end
    iDMemReadyM = 1'b1;
    tick();
    idle();
    tick();
    chk1("wd_sticky", oMemTimeout, 1'b1);

    // Reset mid-wait: immediate reset outputs, counter and flag cleared.
    iDMemReqM = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    iRs1E = 5'd8;
    #2 iRstN = 1'b0;
    now("rst_mid_outs", O_RST);
    chk1("rst_mid_timeout", oMemTimeout, 1'b0);
    @(negedge iClk);
    idle();
    iRstN = 1'b1;
    now("rst_after_run", O_IDLE);
    iDMemReqM = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk1("rst_cnt_cleared", oMemTimeout, 1'b0);
    idle();
    tick();

    // Reset during RPEND drops the pending redirect.
    iMispredictE = 1'b1; iIMemReadyF = 1'b0;
    now("rst_rp_misp", O_MISPW);
    tick();
    iMispredictE = 1'b0;
    #2 iRstN = 1'b0;
    @(negedge iClk);
    iRstN = 1'b1;
    iIMemReadyF = 1'b1;
    now("rst_rp_dropped", O_IDLE);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
